boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 38 +++
 rtl/boot_loader_if.sv | 32 +++
 rtl/boot_loader_byte_packer.sv | 43 ++++
 rtl/boot_loader.sv | 206 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, memory geometry
// defaults, header limits and small state-decode helpers.
package boot_pkg;

    // Default memory geometry; the port address widths below are sized for these.
    localparam int DEF_IMEM_WORDS = 256;
    localparam int DEF_DMEM_BYTES = 32;
    localparam int IMEM_AW        = 8;
    localparam int DMEM_AW        = 5;

    // Smallest legal word count in the header (an empty program is rejected).
    localparam logic [15:0] HDR_MIN_WORDS = 16'd1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR_I  = 4'd1,
        S_CLR_D  = 4'd2,
        S_HDR_LO = 4'd3,
        S_HDR_HI = 4'd4,
        S_LOAD_I = 4'd5,
        S_DLEN   = 4'd6,
        S_LOAD_D = 4'd7,
        S_RUN    = 4'd8,
        S_ERR    = 4'd9
    } state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input state_e s);
        return (s == S_HDR_LO) || (s == S_HDR_HI) || (s == S_LOAD_I) ||
               (s == S_DLEN)   || (s == S_LOAD_D);
    endfunction

    // States that make up an active session (clear through data load).
    function automatic logic is_busy_state(input state_e s);
        return (s == S_CLR_I) || (s == S_CLR_D) || is_rx_state(s);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Load-stream handshake plus the instruction- and data-memory write ports.
// The master side feeds bytes and observes writes; the loader is the slave.
interface boot_loader_if;
    import boot_pkg::*;

    logic [7:0]         rx_data_i;
    logic               rx_valid_i;
    logic               rx_ready_o;

    logic               imem_we_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [31:0]        imem_data_o;

    logic               dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [7:0]         dmem_data_o;

    modport master (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o,
        input  imem_we_o, imem_addr_o, imem_data_o,
        input  dmem_we_o, dmem_addr_o, dmem_data_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o,
        output imem_we_o, imem_addr_o, imem_data_o,
        output dmem_we_o, dmem_addr_o, dmem_data_o
    );

endinterface

// File: rtl/boot_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word. The completed word
// and its valid pulse are presented combinationally alongside the 4th byte so
// the caller can register the memory write on that same accepting edge.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  r_cnt;
    logic [23:0] r_bytes;

    // Byte position within the word; reset or clear discards a partial word.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_i || clear_i) begin
            r_cnt <= 2'd0;
        end else if (valid_i) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Byte storage for the lower three lanes.
    always_ff @(posedge clk_i) begin
        // NOTE: pure data storage needs no reset; r_cnt alone decides what is meaningful.
        if (valid_i) begin
            case (r_cnt)
                2'd0:    r_bytes[7:0]   <= byte_i;
                2'd1:    r_bytes[15:8]  <= byte_i;
                2'd2:    r_bytes[23:16] <= byte_i;
                default: r_bytes        <= r_bytes;
            endcase
        end
    end

    assign word_o       = {byte_i, r_bytes};
    assign word_valid_o = valid_i && !clear_i && (r_cnt == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: clears instruction and data memory, then receives a byte
// stream (word count, program words, data length, data bytes) and writes it
// into both memories before releasing the CPU from reset and starting it.
module boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int DMEM_BYTES = DEF_DMEM_BYTES
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          go_i,
    boot_loader_if.slave  bus,
    output logic          cpu_rst_o,
    output logic          cpu_start_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [15:0] IMEM_MAX  = 16'(IMEM_WORDS);
    localparam logic [15:0] IMEM_LAST = 16'(IMEM_WORDS - 1);
    localparam logic [15:0] DMEM_LAST = 16'(DMEM_BYTES - 1);
    localparam logic [7:0]  DMEM_MAX  = 8'(DMEM_BYTES);

    state_e             r_state;
    logic [15:0]        r_clr_cnt;
    logic [15:0]        r_word_cnt;
    logic [15:0]        r_n;
    logic [7:0]         r_n_lo;
    logic [7:0]         r_byte_cnt;
    logic [7:0]         r_m;

    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_data;
    logic               r_dmem_we;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic [7:0]         r_dmem_data;

    logic               w_ready;
    logic               w_accept;
    logic [15:0]        w_hdr_n;
    logic [31:0]        w_word;
    logic               w_word_valid;

    assign w_ready  = is_rx_state(r_state);
    assign w_accept = bus.rx_valid_i && w_ready;
    assign w_hdr_n  = {bus.rx_data_i, r_n_lo};

    // The packer is held clear outside LOAD_I, so a session abandoned by
    // reset or restart can never leak a partial word into the next one.
    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (r_state != S_LOAD_I),
        .byte_i       (bus.rx_data_i),
        .valid_i      (w_accept && (r_state == S_LOAD_I)),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    // Session FSM with registered memory write ports.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_n         <= 16'd0;
            r_n_lo      <= 8'd0;
            r_byte_cnt  <= 8'd0;
            r_m         <= 8'd0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= 32'd0;
            r_dmem_we   <= 1'b0;
            r_dmem_addr <= '0;
            r_dmem_data <= 8'd0;
        end else begin
            // Write strobes are single-cycle unless a state re-asserts them.
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (go_i) begin
                        r_state   <= S_CLR_I;
                        r_clr_cnt <= 16'd0;
                    end
                end

                S_CLR_I: begin
                    r_imem_we   <= 1'b1;
                    r_imem_addr <= r_clr_cnt[IMEM_AW-1:0];
                    r_imem_data <= 32'd0;
                    if (r_clr_cnt == IMEM_LAST) begin
                        r_clr_cnt <= 16'd0;
                        r_state   <= S_CLR_D;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 16'd1;
                    end
                end

                S_CLR_D: begin
                    r_dmem_we   <= 1'b1;
                    r_dmem_addr <= r_clr_cnt[DMEM_AW-1:0];
                    r_dmem_data <= 8'd0;
                    if (r_clr_cnt == DMEM_LAST) begin
                        r_clr_cnt <= 16'd0;
                        r_state   <= S_HDR_LO;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 16'd1;
                    end
                end

                S_HDR_LO: begin
                    if (w_accept) begin
                        r_n_lo  <= bus.rx_data_i;
                        r_state <= S_HDR_HI;
                    end
                end

                S_HDR_HI: begin
                    if (w_accept) begin
                        r_n        <= w_hdr_n;
                        r_word_cnt <= 16'd0;
                        if (w_hdr_n < HDR_MIN_WORDS || w_hdr_n > IMEM_MAX) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_LOAD_I;
                        end
                    end
                end

                S_LOAD_I: begin
                    if (w_word_valid) begin
                        r_imem_we   <= 1'b1;
                        r_imem_addr <= r_word_cnt[IMEM_AW-1:0];
                        r_imem_data <= w_word;
                        // Leaving on the last word keeps the address from wrapping.
                        if (r_word_cnt + 16'd1 == r_n) begin
                            r_state <= S_DLEN;
                        end else begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                        end
                    end
                end

                S_DLEN: begin
                    if (w_accept) begin
                        r_m        <= bus.rx_data_i;
                        r_byte_cnt <= 8'd0;
                        if (bus.rx_data_i > DMEM_MAX) begin
                            r_state <= S_ERR;
                        end else if (bus.rx_data_i == 8'd0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_LOAD_D;
                        end
                    end
                end

                S_LOAD_D: begin
                    if (w_accept) begin
                        r_dmem_we   <= 1'b1;
                        r_dmem_addr <= r_byte_cnt[DMEM_AW-1:0];
                        r_dmem_data <= bus.rx_data_i;
                        if (r_byte_cnt + 8'd1 == r_m) begin
                            r_state <= S_RUN;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                        end
                    end
                end

                S_RUN, S_ERR: begin
                    // ready is low here, so go_i is the only possible event.
                    if (go_i) begin
                        r_state    <= S_CLR_I;
                        r_clr_cnt  <= 16'd0;
                        r_word_cnt <= 16'd0;
                        r_byte_cnt <= 8'd0;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready_o  = w_ready;
    assign bus.imem_we_o   = r_imem_we;
    assign bus.imem_addr_o = r_imem_addr;
    assign bus.imem_data_o = r_imem_data;
    assign bus.dmem_we_o   = r_dmem_we;
    assign bus.dmem_addr_o = r_dmem_addr;
    assign bus.dmem_data_o = r_dmem_data;

    // Status and CPU control decode straight from the registered state.
    assign cpu_rst_o   = (r_state == S_RUN);
    assign cpu_start_o = (r_state == S_RUN);
    assign done_o      = (r_state == S_RUN);
    assign err_o       = (r_state == S_ERR);
    assign busy_o      = is_busy_state(r_state);

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
module tb_boot_loader;

    logic clk_i = 1'b0;
    logic rst_i;
    logic go_i;
    logic cpu_rst_o, cpu_start_o, busy_o, done_o, err_o;

    boot_loader_if bus();

    boot_loader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .go_i        (go_i),
        .bus         (bus),
        .cpu_rst_o   (cpu_rst_o),
        .cpu_start_o (cpu_start_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    // Shadow memories and counters built from observed write strobes.
    logic [31:0] imem_mem [256];
    logic [7:0]  dmem_mem [32];
    int          imem_wr_cnt = 0;
    int          imem_nz_cnt = 0;
    int          dmem_wr_cnt = 0;
    logic [7:0]  imem_last_addr = 8'd0;

    always @(negedge clk_i) begin
        if (bus.imem_we_o) begin
            imem_mem[bus.imem_addr_o] = bus.imem_data_o;
            imem_wr_cnt++;
            imem_last_addr = bus.imem_addr_o;
            if (bus.imem_data_o != 32'd0) imem_nz_cnt++;
        end
        if (bus.dmem_we_o) begin
            dmem_mem[bus.dmem_addr_o] = bus.dmem_data_o;
            dmem_wr_cnt++;
        end
    end

    task automatic go_pulse();
        go_i = 1'b1;
        @(posedge clk_i); #1;
        go_i = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_i);
        #1;
    endtask

    // Wait (bounded) for the clear phase to finish and the header to be awaited.
    task automatic wait_ready();
        for (int i = 0; i < 400; i++) begin
            if (bus.rx_ready_o) break;
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (bus.rx_ready_o !== 1'b1) begin
            $display("FAIL wait_ready: rx_ready_o=%b required 1 within 400 cycles", bus.rx_ready_o);
            n_fails++;
        end
        @(negedge clk_i); #1;
    endtask

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.rx_ready_o) begin
                @(posedge clk_i); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_byte timeout: byte %h not accepted, ready=%b required 1", b, bus.rx_ready_o);
            bus.rx_valid_i = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        n_checks++; if (bus.rx_ready_o !== 1'b0) begin $display("FAIL reset_ready: got %b need 0", bus.rx_ready_o); n_fails++; end
        n_checks++; if (cpu_rst_o !== 1'b0) begin $display("FAIL reset_cpu_rst: got %b need 0", cpu_rst_o); n_fails++; end
        n_checks++; if (cpu_start_o !== 1'b0) begin $display("FAIL reset_cpu_start: got %b need 0", cpu_start_o); n_fails++; end
        n_checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin $display("FAIL reset_status: got %b need 000", {busy_o, done_o, err_o}); n_fails++; end
        n_checks++; if ({bus.imem_we_o, bus.dmem_we_o} !== 2'b00) begin $display("FAIL reset_we: got %b need 00", {bus.imem_we_o, bus.dmem_we_o}); n_fails++; end
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i); #1;
        n_checks++; if ({busy_o, bus.rx_ready_o, bus.imem_we_o} !== 3'b000) begin $display("FAIL idle_hold: got %b need 000", {busy_o, bus.rx_ready_o, bus.imem_we_o}); n_fails++; end
    endtask

    task automatic test_basic_load();
        int i_base, d_base, nz_base;
        i_base = imem_wr_cnt; d_base = dmem_wr_cnt; nz_base = imem_nz_cnt;
        go_pulse();
        n_checks++; if (busy_o !== 1'b1) begin $display("FAIL basic_busy: got %b need 1", busy_o); n_fails++; end
        repeat (10) @(posedge clk_i); #1;
        go_pulse();  // ignored while clearing
        wait_ready();
        n_checks++; if (imem_wr_cnt - i_base !== 256) begin $display("FAIL clr_imem_count: got %0d need 256", imem_wr_cnt - i_base); n_fails++; end
        n_checks++; if (imem_last_addr !== 8'd255) begin $display("FAIL clr_imem_last: got %0d need 255", imem_last_addr); n_fails++; end
        n_checks++; if (imem_nz_cnt - nz_base !== 0) begin $display("FAIL clr_imem_zero: got %0d nonzero need 0", imem_nz_cnt - nz_base); n_fails++; end
        n_checks++; if (dmem_wr_cnt - d_base !== 32) begin $display("FAIL clr_dmem_count: got %0d need 32", dmem_wr_cnt - d_base); n_fails++; end
        i_base = imem_wr_cnt; d_base = dmem_wr_cnt;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        n_checks++; if (bus.imem_we_o !== 1'b0) begin $display("FAIL early_we: got %b need 0", bus.imem_we_o); n_fails++; end
        send_byte(8'h00);
        n_checks++; if ({bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o} !== {1'b1, 8'd0, 32'h00000013}) begin
            $display("FAIL word0_write: got we=%b a=%0d d=%h need 1/0/00000013", bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o); n_fails++; end
        send_word(32'h00000820);
        n_checks++; if ({bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o} !== {1'b1, 8'd1, 32'h00000820}) begin
            $display("FAIL word1_write: got we=%b a=%0d d=%h need 1/1/00000820", bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o); n_fails++; end
        n_checks++; if ({bus.rx_ready_o, busy_o, done_o} !== 3'b110) begin $display("FAIL dlen_state: got %b need 110", {bus.rx_ready_o, busy_o, done_o}); n_fails++; end
        send_byte(8'h01); send_byte(8'h05);
        bus.rx_valid_i = 1'b0;
        n_checks++; if ({bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_data_o} !== {1'b1, 5'd0, 8'h05}) begin
            $display("FAIL dmem_write: got we=%b a=%0d d=%h need 1/0/05", bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_data_o); n_fails++; end
        n_checks++; if ({done_o, cpu_rst_o, cpu_start_o, busy_o, bus.rx_ready_o} !== 5'b11100) begin
            $display("FAIL run_outputs: got %b need 11100", {done_o, cpu_rst_o, cpu_start_o, busy_o, bus.rx_ready_o}); n_fails++; end
        settle();
        n_checks++; if (imem_mem[0] !== 32'h00000013) begin $display("FAIL basic_imem0: got %h need 00000013", imem_mem[0]); n_fails++; end
        n_checks++; if (imem_mem[1] !== 32'h00000820) begin $display("FAIL basic_imem1: got %h need 00000820", imem_mem[1]); n_fails++; end
        n_checks++; if (dmem_mem[0] !== 8'h05) begin $display("FAIL basic_dmem0: got %h need 05", dmem_mem[0]); n_fails++; end
        n_checks++; if (imem_wr_cnt - i_base !== 2) begin $display("FAIL basic_imem_count: got %0d need 2", imem_wr_cnt - i_base); n_fails++; end
        n_checks++; if (dmem_wr_cnt - d_base !== 1) begin $display("FAIL basic_dmem_count: got %0d need 1", dmem_wr_cnt - d_base); n_fails++; end
    endtask

    task automatic test_toggle_valid();
        int i_base;
        logic [7:0] bytes [8];
        bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00};
        go_pulse();
        wait_ready();
        i_base = imem_wr_cnt;
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            bus.rx_valid_i = 1'b0;
            if (i == 4) go_i = 1'b1;  // ignored during LOAD_I
            @(posedge clk_i); #1;
            go_i = 1'b0;
        end
        send_byte(8'h01); send_byte(8'h05);
        bus.rx_valid_i = 1'b0;
        settle();
        n_checks++; if (imem_wr_cnt - i_base !== 2) begin $display("FAIL toggle_we_count: got %0d need 2", imem_wr_cnt - i_base); n_fails++; end
        n_checks++; if ({imem_mem[0], imem_mem[1]} !== {32'h00000013, 32'h00000820}) begin
            $display("FAIL toggle_image: got %h %h need 00000013 00000820", imem_mem[0], imem_mem[1]); n_fails++; end
        n_checks++; if ({dmem_mem[0], done_o} !== {8'h05, 1'b1}) begin $display("FAIL toggle_done: got dmem0=%h done=%b need 05/1", dmem_mem[0], done_o); n_fails++; end
    endtask

    task automatic test_reset_mid();
        int i_base, d_base;
        go_pulse();
        wait_ready();
        i_base = imem_wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rst_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        n_checks++; if ({bus.rx_ready_o, busy_o, done_o, err_o, cpu_rst_o, cpu_start_o, bus.imem_we_o} !== 7'b0) begin
            $display("FAIL midreset_outputs: got %b need 0000000", {bus.rx_ready_o, busy_o, done_o, err_o, cpu_rst_o, cpu_start_o, bus.imem_we_o}); n_fails++; end
        settle();
        n_checks++; if (imem_wr_cnt - i_base !== 0) begin $display("FAIL midreset_no_write: got %0d writes need 0", imem_wr_cnt - i_base); n_fails++; end
        // Fresh session: stale bytes must not merge into the new word; M=0 goes straight to RUN.
        go_pulse();
        wait_ready();
        d_base = dmem_wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDDCCBBAA);
        send_byte(8'h00);
        bus.rx_valid_i = 1'b0;
        n_checks++; if ({done_o, cpu_rst_o} !== 2'b11) begin $display("FAIL m0_run: got %b need 11", {done_o, cpu_rst_o}); n_fails++; end
        settle();
        n_checks++; if (imem_mem[0] !== 32'hDDCCBBAA) begin $display("FAIL fresh_word: got %h need ddccbbaa", imem_mem[0]); n_fails++; end
        n_checks++; if (dmem_wr_cnt - d_base !== 0) begin $display("FAIL m0_no_dmem: got %0d writes need 0", dmem_wr_cnt - d_base); n_fails++; end
    endtask

    task automatic test_bad_header();
        int i_base;
        go_pulse();
        wait_ready();
        i_base = imem_wr_cnt;
        send_byte(8'h01); send_byte(8'h01);
        bus.rx_valid_i = 1'b0;
        n_checks++; if ({err_o, bus.rx_ready_o, cpu_rst_o, busy_o, done_o} !== 5'b10000) begin
            $display("FAIL n257_err: got %b need 10000", {err_o, bus.rx_ready_o, cpu_rst_o, busy_o, done_o}); n_fails++; end
        repeat (4) @(posedge clk_i); #1;
        n_checks++; if ({err_o, cpu_rst_o} !== 2'b10) begin $display("FAIL err_hold: got %b need 10", {err_o, cpu_rst_o}); n_fails++; end
        settle();
        n_checks++; if (imem_wr_cnt - i_base !== 0) begin $display("FAIL n257_no_write: got %0d need 0", imem_wr_cnt - i_base); n_fails++; end
        go_pulse();  // restart from ERR
        n_checks++; if ({err_o, busy_o} !== 2'b01) begin $display("FAIL err_restart: got %b need 01", {err_o, busy_o}); n_fails++; end
        wait_ready();
        send_byte(8'h00); send_byte(8'h00);
        bus.rx_valid_i = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin $display("FAIL n0_err: got %b need 1", err_o); n_fails++; end
    endtask

    task automatic test_full_load();
        int i_base, d_base;
        go_pulse();
        wait_ready();
        i_base = imem_wr_cnt;
        send_byte(8'h00); send_byte(8'h01);
        for (int w = 0; w < 256; w++) send_word(32'hC0000000 | 32'(w));
        n_checks++; if ({bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o} !== {1'b1, 8'd255, 32'hC00000FF}) begin
            $display("FAIL full_last_write: got we=%b a=%0d d=%h need 1/255/c00000ff", bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o); n_fails++; end
        n_checks++; if ({bus.rx_ready_o, busy_o} !== 2'b11) begin $display("FAIL full_dlen: got %b need 11", {bus.rx_ready_o, busy_o}); n_fails++; end
        bus.rx_valid_i = 1'b0;
        settle();
        n_checks++; if (imem_wr_cnt - i_base !== 256) begin $display("FAIL full_count: got %0d need 256", imem_wr_cnt - i_base); n_fails++; end
        n_checks++; if ({imem_mem[0], imem_mem[255], imem_last_addr} !== {32'hC0000000, 32'hC00000FF, 8'd255}) begin
            $display("FAIL full_image: got %h %h last=%0d need c0000000 c00000ff 255", imem_mem[0], imem_mem[255], imem_last_addr); n_fails++; end
        send_byte(8'h21);  // M=33 exceeds data memory
        bus.rx_valid_i = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin $display("FAIL m33_err: got %b need 1", err_o); n_fails++; end
        // M=32 is the largest legal data length.
        go_pulse();
        wait_ready();
        d_base = dmem_wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h04030201);
        send_byte(8'h20);
        for (int b = 0; b < 32; b++) send_byte(8'h40 + 8'(b));
        bus.rx_valid_i = 1'b0;
        n_checks++; if (done_o !== 1'b1) begin $display("FAIL m32_done: got %b need 1", done_o); n_fails++; end
        settle();
        n_checks++; if (dmem_wr_cnt - d_base !== 32) begin $display("FAIL m32_count: got %0d need 32", dmem_wr_cnt - d_base); n_fails++; end
        n_checks++; if ({dmem_mem[0], dmem_mem[31]} !== {8'h40, 8'h5F}) begin $display("FAIL m32_image: got %h %h need 40 5f", dmem_mem[0], dmem_mem[31]); n_fails++; end
    endtask

    task automatic test_go_in_run();
        int i_base, nz_base;
        i_base = imem_wr_cnt; nz_base = imem_nz_cnt;
        go_pulse();
        n_checks++; if ({cpu_rst_o, cpu_start_o, done_o, busy_o} !== 4'b0001) begin
            $display("FAIL run_restart: got %b need 0001", {cpu_rst_o, cpu_start_o, done_o, busy_o}); n_fails++; end
        wait_ready();
        n_checks++; if (imem_wr_cnt - i_base !== 256) begin $display("FAIL restart_clr_count: got %0d need 256", imem_wr_cnt - i_base); n_fails++; end
        n_checks++; if (imem_nz_cnt - nz_base !== 0) begin $display("FAIL restart_clr_zero: got %0d nonzero need 0", imem_nz_cnt - nz_base); n_fails++; end
    endtask

    initial begin
        rst_i          = 1'b0;
        go_i           = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        test_reset();
        test_basic_load();
        test_toggle_valid();
        test_reset_mid();
        test_bad_header();
        test_full_load();
        test_go_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
